// File: rtl/hankel_matrix_writer.sv
// rtl/hankel_matrix_writer.sv - buffers a Hankel generating sequence and writes the full matrix to memory
module hankel_matrix_writer #(
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int WIDTH = 16,
  parameter int ADDR  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ADDR-1:0]  addr,
  output logic [WIDTH-1:0] wdata,
  output logic             wr,
  input  logic             wait_req,
  output logic             busy,
  output logic             done
);

  localparam int LEN = ROW + COL - 1;
  localparam int KW  = $clog2(LEN);
  localparam int RW  = $clog2(ROW);
  localparam int CW  = $clog2(COL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic             in_ready_n, wr_n, busy_n, done_n;
  logic [ADDR-1:0]  addr_n;
  logic [WIDTH-1:0] wdata_n;
  logic [KW-1:0]    k, k_n;
  logic [RW-1:0]    r, r_n;
  logic [CW-1:0]    c, c_n;
  logic [KW-1:0]    rd_idx;
  logic             load_fire;

  // Generating sequence buffer; contents are irrelevant until fully loaded, so no reset
  logic [WIDTH-1:0] seq [LEN];

  // Capture one sequence element per accepted input beat
  always_ff @(posedge clk) begin
    if (load_fire) begin
      seq[k] <= in_data;
    end
  end

  // State, counters and every output are registered; next values come from the comb block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      wr       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      k        <= '0;
      r        <= '0;
      c        <= '0;
    end else begin
      state    <= state_n;
      in_ready <= in_ready_n;
      wr       <= wr_n;
      addr     <= addr_n;
      wdata    <= wdata_n;
      busy     <= busy_n;
      done     <= done_n;
      k        <= k_n;
      r        <= r_n;
      c        <= c_n;
    end
  end

  // Next-state and next-output logic; the write address simply increments because
  // row-major order makes r*COL+c consecutive, and r+c always stays inside the buffer
  always_comb begin
    state_n    = state;
    in_ready_n = in_ready;
    wr_n       = wr;
    addr_n     = addr;
    wdata_n    = wdata;
    busy_n     = busy;
    done_n     = 1'b0;
    k_n        = k;
    r_n        = r;
    c_n        = c;
    load_fire  = 1'b0;
    rd_idx     = '0;

    case (state)
      S_IDLE: begin
        in_ready_n = 1'b0;
        wr_n       = 1'b0;
        busy_n     = 1'b0;
        if (start) begin
          state_n    = S_LOAD;
          k_n        = '0;
          busy_n     = 1'b1;
          in_ready_n = 1'b1;
        end
      end

      S_LOAD: begin
        if (in_valid && in_ready) begin
          load_fire = 1'b1;
          if (k == KW'(LEN - 1)) begin
            state_n    = S_WRITE;
            in_ready_n = 1'b0;
            r_n        = '0;
            c_n        = '0;
            wr_n       = 1'b1;
            addr_n     = '0;
            wdata_n    = seq[0];
          end else begin
            k_n = k + KW'(1);
          end
        end
      end

      S_WRITE: begin
        if (!wait_req) begin
          if ((r == RW'(ROW - 1)) && (c == CW'(COL - 1))) begin
            state_n = S_DONE;
            wr_n    = 1'b0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            if (c == CW'(COL - 1)) begin
              c_n = '0;
              r_n = r + RW'(1);
            end else begin
              c_n = c + CW'(1);
            end
            rd_idx  = KW'(r_n) + KW'(c_n);
            addr_n  = addr + ADDR'(1);
            wdata_n = seq[rd_idx];
          end
        end
      end

      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end

      default: begin
        state_n    = S_IDLE;
        in_ready_n = 1'b0;
        wr_n       = 1'b0;
        busy_n     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_hankel_matrix_writer.sv
// tb/tb_hankel_matrix_writer.sv - directed table-driven bench for hankel_matrix_writer
module tb_hankel_matrix_writer;

  typedef struct {
    logic [15:0] h;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, wait_req, sel;
  logic [15:0] in_data;
  logic        start_a, start_b;

  logic        a_in_ready, a_wr, a_busy, a_done;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata;
  logic        b_in_ready, b_wr, b_busy, b_done;
  logic [7:0]  b_addr;
  logic [15:0] b_wdata;

  logic        in_ready, wr, busy, done;
  logic [7:0]  addr;
  logic [15:0] wdata;

  vec_t tab   [16];
  vec_t tab_b [6];
  vec_t cur   [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign start_a  = start & ~sel;
  assign start_b  = start & sel;
  assign in_ready = sel ? b_in_ready : a_in_ready;
  assign wr       = sel ? b_wr       : a_wr;
  assign busy     = sel ? b_busy     : a_busy;
  assign done     = sel ? b_done     : a_done;
  assign addr     = sel ? b_addr     : a_addr;
  assign wdata    = sel ? b_wdata    : a_wdata;

  hankel_matrix_writer #(.ROW(4), .COL(4), .WIDTH(16), .ADDR(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .addr(a_addr), .wdata(a_wdata), .wr(a_wr),
    .wait_req(wait_req), .busy(a_busy), .done(a_done)
  );

  hankel_matrix_writer #(.ROW(2), .COL(3), .WIDTH(16), .ADDR(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .addr(b_addr), .wdata(b_wdata), .wr(b_wr),
    .wait_req(wait_req), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int nh, input int nw, input bit toggle,
                     input int stall_at, input int stall_len, input bit poke_start);
    int sent, widx, cyc, stalls, held, rdy;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 1);
    sent = 0; cyc = 0; rdy = 0;
    while (sent < nh && cyc < 100) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = cur[sent].h;
      chk("no_wr_in_load", wr, 0);
      if (in_ready) rdy++;
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("inputs_taken", sent, nh);
    if (!toggle) chk("in_ready_cycles", rdy, nh);
    chk("in_ready_drop", in_ready, 0);
    widx = 0; cyc = 0; stalls = 0; held = 0;
    while (widx < nw && cyc < 200) begin
      chk("wr", wr, 1);
      chk("addr", addr, cur[widx].addr);
      chk("wdata", wdata, cur[widx].wdata);
      if (widx == stall_at) held++;
      start = poke_start && (widx == 3);
      if (widx == stall_at && stalls < stall_len) begin
        wait_req = 1'b1;
        stalls++;
      end else begin
        wait_req = 1'b0;
        widx++;
      end
      @(negedge clk);
      cyc++;
    end
    wait_req = 1'b0;
    start    = 1'b0;
    chk("write_count", widx, nw);
    if (stall_at >= 0) chk("held_cycles", held, stall_len + 1);
    chk("done_pulse", done, 1);
    chk("wr_off_at_done", wr, 0);
    chk("busy_off_at_done", busy, 0);
    start = poke_start;
    @(negedge clk);
    start = 1'b0;
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_wr", wr, 0);
  endtask

  initial begin
    tab[0]  = '{16'd1, 8'd0,  16'd1};
    tab[1]  = '{16'd2, 8'd1,  16'd2};
    tab[2]  = '{16'd3, 8'd2,  16'd3};
    tab[3]  = '{16'd4, 8'd3,  16'd4};
    tab[4]  = '{16'd5, 8'd4,  16'd2};
    tab[5]  = '{16'd6, 8'd5,  16'd3};
    tab[6]  = '{16'd7, 8'd6,  16'd4};
    tab[7]  = '{16'd0, 8'd7,  16'd5};
    tab[8]  = '{16'd0, 8'd8,  16'd3};
    tab[9]  = '{16'd0, 8'd9,  16'd4};
    tab[10] = '{16'd0, 8'd10, 16'd5};
    tab[11] = '{16'd0, 8'd11, 16'd6};
    tab[12] = '{16'd0, 8'd12, 16'd4};
    tab[13] = '{16'd0, 8'd13, 16'd5};
    tab[14] = '{16'd0, 8'd14, 16'd6};
    tab[15] = '{16'd0, 8'd15, 16'd7};
    tab_b[0] = '{16'd10, 8'd0, 16'd10};
    tab_b[1] = '{16'd20, 8'd1, 16'd20};
    tab_b[2] = '{16'd30, 8'd2, 16'd30};
    tab_b[3] = '{16'd40, 8'd3, 16'd20};
    tab_b[4] = '{16'd0,  8'd4, 16'd30};
    tab_b[5] = '{16'd0,  8'd5, 16'd40};
    cur = tab;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; wait_req = 1'b0;
    in_data = 16'd0; sel = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr", wr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset asserted in the middle of the write phase
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h55aa;
    for (int i = 0; i < 30 && !wr; i++) @(negedge clk);
    chk("reached_write", wr, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_wr", wr, 0);
    chk("abort_addr", addr, 0);
    chk("abort_wdata", wdata, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_abort_in_ready", in_ready, 0);
      chk("post_abort_busy", busy, 0);
    end
    in_valid = 1'b0;

    run(7, 16, 1'b0, -1, 0, 1'b0);
    run(7, 16, 1'b1, -1, 0, 1'b0);
    run(7, 16, 1'b0, 5, 3, 1'b0);
    run(7, 16, 1'b0, -1, 0, 1'b1);

    sel = 1'b1;
    for (int i = 0; i < 6; i++) cur[i] = tab_b[i];
    run(4, 6, 1'b0, -1, 0, 1'b0);
    run(4, 6, 1'b0, 2, 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
